// File: rtl/ws2812_pkg.sv
// ws2812_pkg: state encoding and default WS2812 timing shared by the receiver
// and the transmitter. All timing constants are in clock cycles.
package ws2812_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,  // waiting for a full reset gap before trusting the line
        IDLE = 2'd1,  // between frames
        HIGH = 2'd2,  // measuring a high pulse
        LOW  = 2'd3   // low phase between bits of a frame
    } ws2812_state_e;

    localparam int DEF_CLK_FRE = 27_000_000;
    localparam int DEF_WIDTH   = 24;

    // Integer arithmetic so fractional cycle counts truncate rather than round.
    function automatic int ns_to_cycles(input int clk_fre, input int ns);
        return clk_fre / 1_000_000 * ns / 1000;
    endfunction

    localparam int DEF_T_MIN_HIGH = ns_to_cycles(DEF_CLK_FRE, 150);     // 4
    localparam int DEF_T_THRESH   = ns_to_cycles(DEF_CLK_FRE, 625);     // 16
    localparam int DEF_T_MAX_HIGH = ns_to_cycles(DEF_CLK_FRE, 1500);    // 40
    localparam int DEF_T_RESET    = ns_to_cycles(DEF_CLK_FRE, 50_000);  // 1350

endpackage

// File: rtl/ws2812_sync.sv
// ws2812_sync: brings the asynchronous WS2812 line into the clock domain.
// Two-flop synchronizer, a registered copy of the synchronized level, and
// rise/fall strobes aligned with that copy (pin edge to strobe: 3 cycles).
module ws2812_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;

    // Synchronizer chain plus edge register; strobes line up with lvl.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            lvl  <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its predecessor; blocking here would collapse the chain.
            meta <= din;
            sync <= meta;
            lvl  <= sync;
            rise <= sync & ~lvl;
            fall <= ~sync & lvl;
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 one-wire stream decoder. Classifies each high pulse by
// width, assembles LSB-first words, flags frame end on the long low gap.
// Optional macro WS2812_RX_FWD_EN: daisy-chain forwarding on WS2812_Do of
// every word after the first of a frame; undefined, WS2812_Do is tied low.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int CLK_FRE      = DEF_CLK_FRE,
    parameter int WS2812_WIDTH = DEF_WIDTH,
    parameter int T_MIN_HIGH   = ns_to_cycles(CLK_FRE, 150),
    parameter int T_THRESH     = ns_to_cycles(CLK_FRE, 625),
    parameter int T_MAX_HIGH   = ns_to_cycles(CLK_FRE, 1500),
    parameter int T_RESET      = ns_to_cycles(CLK_FRE, 50_000)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    WS2812_Di,
    output logic [WS2812_WIDTH-1:0] data,
    output logic                    data_valid,
    output logic [8:0]              word_idx,
    output logic                    frame_done,
    output logic                    bit_err,
    output logic                    WS2812_Do
);

    localparam int CW = $clog2(T_RESET + 1);
    localparam int BW = (WS2812_WIDTH > 1) ? $clog2(WS2812_WIDTH) : 1;

    localparam logic [CW-1:0] C_MIN      = CW'(T_MIN_HIGH);
    localparam logic [CW-1:0] C_THRESH   = CW'(T_THRESH);
    localparam logic [CW-1:0] C_MAX      = CW'(T_MAX_HIGH);
    localparam logic [CW-1:0] C_RESET    = CW'(T_RESET);
    localparam logic [CW-1:0] C_RESET_M1 = CW'(T_RESET - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(WS2812_WIDTH - 1);

    logic lvl, rise, fall;

    ws2812_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (WS2812_Di),
        .lvl  (lvl),
        .rise (rise),
        .fall (fall)
    );

    ws2812_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [WS2812_WIDTH-1:0] shift_q, shift_d, data_d;
    logic [8:0] word_cnt_q, word_cnt_d, word_idx_d;
    logic seen_q, seen_d;
    logic dv_d, fd_d, err_d, abort;

    // Next-state and output decode. cnt always holds the number of cycles
    // spent at the current level, including the current one.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one
        // unassigned and no latch is inferred.
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        word_cnt_d = word_cnt_q;
        seen_d     = seen_q;
        data_d     = data;
        word_idx_d = word_idx;
        dv_d       = 1'b0;
        fd_d       = 1'b0;
        err_d      = 1'b0;
        abort      = 1'b0;
        cnt_inc    = (cnt_q >= C_RESET) ? C_RESET : cnt_q + CW'(1);

        unique case (state_q)
            SYNC: begin
                if (lvl) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == C_RESET) state_d = IDLE;
                end
            end
            IDLE, LOW: begin
                cnt_d = cnt_inc;
                // Frame end is evaluated before a coincident rising edge.
                if (cnt_q == C_RESET_M1) begin
                    fd_d       = seen_q;
                    err_d      = (bit_cnt_q != '0);
                    seen_d     = 1'b0;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    word_idx_d = '0;
                    state_d    = IDLE;
                end
                if (rise) begin
                    cnt_d   = CW'(1);
                    seen_d  = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    if (cnt_q < C_MIN) begin
                        abort = 1'b1;
                    end else begin
                        shift_d[bit_cnt_q] = (cnt_q >= C_THRESH);
                        cnt_d   = CW'(1);
                        state_d = LOW;
                        if (bit_cnt_q == LAST_BIT) begin
                            data_d     = shift_d;
                            dv_d       = 1'b1;
                            word_idx_d = word_cnt_q;
                            bit_cnt_d  = '0;
                            if (word_cnt_q != 9'h1FF) word_cnt_d = word_cnt_q + 9'd1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end else if (cnt_q >= C_MAX) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = SYNC;
        endcase

        // An illegal pulse kills the frame: resynchronise on a full gap.
        if (abort) begin
            err_d      = 1'b1;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            seen_d     = 1'b0;
            cnt_d      = '0;
            state_d    = SYNC;
        end
    end

    // State, counters, assembly register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the shift register is reset along with everything else so
            // no stale bits survive a mid-word reset.
            state_q    <= SYNC;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            word_cnt_q <= '0;
            seen_q     <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            word_idx   <= '0;
            frame_done <= 1'b0;
            bit_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            word_cnt_q <= word_cnt_d;
            seen_q     <= seen_d;
            data       <= data_d;
            data_valid <= dv_d;
            word_idx   <= word_idx_d;
            frame_done <= fd_d;
            bit_err    <= err_d;
        end
    end

`ifdef WS2812_RX_FWD_EN
    logic fwd_active;

    // Arm forwarding once the first word of a frame is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_active <= 1'b0;
        end else if (frame_done || bit_err) begin
            fwd_active <= 1'b0;
        end else if (data_valid && (word_idx == 9'd0)) begin
            fwd_active <= 1'b1;
        end
    end

    // lvl is the pin delayed by three register stages.
    assign WS2812_Do = fwd_active & lvl;
`else
    assign WS2812_Do = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: self-checking bench for ws2812_rx. Expected words are queued
// when sent and compared when data_valid fires; pulse counters cover
// frame_done / bit_err; WS2812_Do is compared against a delayed pin model.
module tb_ws2812_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic [23:0] data;
    logic        data_valid;
    logic [8:0]  word_idx;
    logic        frame_done;
    logic        bit_err;
    logic        WS2812_Do;

    ws2812_rx dut (
        .clk        (clk),
        .rst        (rst),
        .WS2812_Di  (din),
        .data       (data),
        .data_valid (data_valid),
        .word_idx   (word_idx),
        .frame_done (frame_done),
        .bit_err    (bit_err),
        .WS2812_Do  (WS2812_Do)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] word;
        logic [8:0]  idx;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int fd_cnt = 0, err_cnt = 0, both_cnt = 0, do_bad = 0, do_ones = 0;
    logic [3:0]  hist = '0;
    logic        fwd_exp = 1'b0;
    logic [23:0] last_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: one sample per cycle, just after the pin is driven.
    initial begin
        exp_t e;
        logic first;
        forever begin
            @(negedge clk);
            #1;
            first = 1'b0;
            hist = {hist[2:0], din};
            if (rst) fwd_exp = 1'b0;
            if (WS2812_Do !== (fwd_exp ? hist[3] : 1'b0)) do_bad++;
            if (WS2812_Do === 1'b1) do_ones++;
            if (data_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("dv_unexpected", 32'(data_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("dv_data", 32'(data), 32'(e.word));
                    check("dv_idx", 32'(word_idx), 32'(e.idx));
                    first = (e.idx == 9'd0);
                end
            end
            if (frame_done === 1'b1) fd_cnt++;
            if (bit_err === 1'b1) err_cnt++;
            if (frame_done === 1'b1 && bit_err === 1'b1) both_cnt++;
`ifdef WS2812_RX_FWD_EN
            if (frame_done === 1'b1 || bit_err === 1'b1) fwd_exp = 1'b0;
            else if (first) fwd_exp = 1'b1;
`endif
        end
    end

    // Watchdog: the stimulus is fixed-length, so this only trips on a hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Hold the pin at v for n cycles, changing it only on a falling clock edge.
    task automatic drive(input logic v, input int n);
        @(negedge clk);
        din = v;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        drive(1'b1, hi);
        drive(1'b0, lo);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 0; i < 24; i++) pulse(w[i] ? 23 : 11, w[i] ? 12 : 23);
    endtask

    task automatic expect_word(input logic [23:0] w, input logic [8:0] idx);
        sb.push_back('{word: w, idx: idx});
        last_word = w;
    endtask

    task automatic gap(input int n);
        drive(1'b0, n);
        #2;
    endtask

    exp_t vecs[4];
    int   fd0, err0, both0, ones0;
    logic [23:0] bnd;

    initial begin
        vecs[0] = '{word: 24'hA5A5A5, idx: 9'd0};
        vecs[1] = '{word: 24'h00FF00, idx: 9'd1};
        vecs[2] = '{word: 24'hFFFFFF, idx: 9'd2};
        vecs[3] = '{word: 24'h123456, idx: 9'd0};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_data", 32'(data), 32'd0);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_idx", 32'(word_idx), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);
        check("rst_err", 32'(bit_err), 32'd0);
        check("rst_do", 32'(WS2812_Do), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Initial gap only leaves SYNC: no frame_done without an edge
        gap(1400);
        check("sync_no_fd", 32'(fd_cnt), 32'd0);

        // Single word 000001
        expect_word(24'h000001, 9'd0);
        send_word(24'h000001);
        check("w1_delivered", 32'(sb.size()), 32'd0);
        check("w1_data", 32'(data), 32'h000001);
        fd0 = fd_cnt; err0 = err_cnt;
        gap(1400);
        check("w1_fd", 32'(fd_cnt - fd0), 32'd1);
        check("w1_err", 32'(err_cnt - err0), 32'd0);
        check("w1_idx_clr", 32'(word_idx), 32'd0);

        // Three-word frame, then word index restarts
        fd0 = fd_cnt; err0 = err_cnt;
        for (int i = 0; i < 3; i++) begin
            expect_word(vecs[i].word, vecs[i].idx);
            send_word(vecs[i].word);
        end
        gap(1400);
        check("f3_delivered", 32'(sb.size()), 32'd0);
        check("f3_fd", 32'(fd_cnt - fd0), 32'd1);
        check("f3_err", 32'(err_cnt - err0), 32'd0);
        expect_word(vecs[3].word, vecs[3].idx);
        send_word(vecs[3].word);
        gap(1400);
        check("restart_delivered", 32'(sb.size()), 32'd0);

        // Legal boundary widths: 15->0, 16->1, 4->0, 40->1
        bnd = 24'hC3C3CA;
        expect_word(bnd, 9'd0);
        pulse(15, 23);
        pulse(16, 12);
        pulse(4, 23);
        pulse(40, 12);
        for (int i = 4; i < 24; i++) pulse(bnd[i] ? 23 : 11, bnd[i] ? 12 : 23);
        gap(1400);
        check("bnd_delivered", 32'(sb.size()), 32'd0);

        // Too-short pulse: error, then a gapless word is ignored
        err0 = err_cnt; fd0 = fd_cnt;
        for (int i = 0; i < 5; i++) pulse(23, 12);
        pulse(3, 20);
        check("short_err", 32'(err_cnt - err0), 32'd1);
        send_word(24'h777777);
        gap(1400);
        check("short_no_fd", 32'(fd_cnt - fd0), 32'd0);
        expect_word(24'h0F0F0F, 9'd0);
        send_word(24'h0F0F0F);
        gap(1400);
        check("short_recover", 32'(sb.size()), 32'd0);

        // Too-long pulse: error, then a gapless word is ignored
        err0 = err_cnt; fd0 = fd_cnt;
        for (int i = 0; i < 3; i++) pulse(11, 23);
        pulse(41, 20);
        check("long_err", 32'(err_cnt - err0), 32'd1);
        send_word(24'h888888);
        gap(1400);
        check("long_no_fd", 32'(fd_cnt - fd0), 32'd0);
        expect_word(24'hF0F0F0, 9'd0);
        send_word(24'hF0F0F0);
        gap(1400);
        check("long_recover", 32'(sb.size()), 32'd0);

        // Partial word: bit_err and frame_done together, data held
        err0 = err_cnt; fd0 = fd_cnt; both0 = both_cnt;
        for (int i = 0; i < 10; i++) pulse(23, 12);
        gap(1400);
        check("part_err", 32'(err_cnt - err0), 32'd1);
        check("part_fd", 32'(fd_cnt - fd0), 32'd1);
        check("part_same_cycle", 32'(both_cnt - both0), 32'd1);
        check("part_data_held", 32'(data), 32'(last_word));

        // Reset mid-pulse clears outputs; gapless word afterwards is ignored
        err0 = err_cnt; fd0 = fd_cnt;
        drive(1'b1, 20);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_data", 32'(data), 32'd0);
        check("mid_rst_pulses", 32'({data_valid, frame_done, bit_err, WS2812_Do}), 32'd0);
        check("mid_rst_idx", 32'(word_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 30);
        send_word(24'h999999);
        gap(1400);
        check("mid_rst_no_fd", 32'(fd_cnt - fd0), 32'd0);
        check("mid_rst_no_err", 32'(err_cnt - err0), 32'd0);
        expect_word(24'h6B6B6B, 9'd0);
        send_word(24'h6B6B6B);
        gap(1400);
        check("mid_rst_recover", 32'(sb.size()), 32'd0);
        check("mid_rst_fd", 32'(fd_cnt - fd0), 32'd1);

`ifdef WS2812_RX_FWD_EN
        // Forwarding: W0 consumed, W1 appears on WS2812_Do 3 cycles late
        ones0 = do_ones;
        expect_word(24'h5A5A5A, 9'd0);
        send_word(24'h5A5A5A);
        check("fwd_w0_quiet", 32'(do_ones - ones0), 32'd0);
        expect_word(24'h3C3CC3, 9'd1);
        send_word(24'h3C3CC3);
        gap(1400);
        check("fwd_w1_seen", 32'(do_ones > ones0), 32'd1);
        check("fwd_delivered", 32'(sb.size()), 32'd0);
        check("fwd_off_after_fd", 32'(WS2812_Do), 32'd0);
`else
        check("do_never_high", 32'(do_ones), 32'd0);
`endif

        check("do_model", 32'(do_bad), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
